// File: rtl/buffer_wr_ctrl_if.sv
// Bundle of framebuffer-writer signals: camera pixel stream, CPU write
// request, clear request, and the registered RAM write port plus status.
//   master : drives camera/CPU/clear inputs, observes RAM port and status
//   slave  : buffer_wr_ctrl side
interface buffer_wr_ctrl_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic          cam_valid;
  logic          cam_sof;
  logic [DW-1:0] cam_data;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          cpu_ack;
  logic          busy;
  logic          frame_done;
  logic          clr_done;
  logic          overrun;

  modport master (
    output cam_valid, cam_sof, cam_data, cpu_req, cpu_addr, cpu_data,
           clr_start, clr_color,
    input  addr_in, data_in, regwrite, cpu_ack, busy, frame_done,
           clr_done, overrun
  );

  modport slave (
    input  cam_valid, cam_sof, cam_data, cpu_req, cpu_addr, cpu_data,
           clr_start, clr_color,
    output addr_in, data_in, regwrite, cpu_ack, busy, frame_done,
           clr_done, overrun
  );
endinterface

// File: rtl/buffer_wr_ctrl.sv
// Framebuffer write-port arbiter. Camera pixels (never stalled) have
// priority, CPU writes fill idle cycles, and a clear request sweeps the
// whole frame with one colour, during which camera pixels are dropped.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : buffer_wr_ctrl_if.slave (camera/CPU/clear inputs, registered
//          RAM write port addr_in/data_in/regwrite, cpu_ack, busy,
//          frame_done, clr_done, sticky overrun)
module buffer_wr_ctrl #(
  parameter int AW   = 15,
  parameter int DW   = 8,
  parameter int NPIX = 19200
) (
  input logic            clk,
  input logic            rst,
  buffer_wr_ctrl_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  state_t        state, state_d;
  logic [AW-1:0] cam_addr, cam_addr_d;
  logic [AW-1:0] clr_cnt, clr_cnt_d;
  logic [DW-1:0] color, color_d;
  logic [AW-1:0] pix_addr;

  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic          ack_q, ack_d;
  logic          fd_q, fd_d;
  logic          cd_q, cd_d;
  logic          ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cam_addr <= '0;
      clr_cnt  <= '0;
      color    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
      cd_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cam_addr <= cam_addr_d;
      clr_cnt  <= clr_cnt_d;
      color    <= color_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      fd_q     <= fd_d;
      cd_q     <= cd_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state;
    cam_addr_d = cam_addr;
    clr_cnt_d  = clr_cnt;
    color_d    = color;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    ack_d      = 1'b0;
    fd_d       = 1'b0;
    cd_d       = 1'b0;
    ovr_d      = ovr_q;

    // Camera addressing runs in both states so the stream stays aligned
    // even while its pixels are being dropped during a clear.
    pix_addr = bus.cam_sof ? '0 : cam_addr;
    if (bus.cam_valid) begin
      fd_d       = (pix_addr == LAST);
      cam_addr_d = (pix_addr == LAST) ? '0 : pix_addr + AW'(1);
    end else if (bus.cam_sof) begin
      cam_addr_d = '0;
    end

    case (state)
      IDLE: begin
        if (bus.cam_sof) ovr_d = 1'b0;
        if (bus.cam_valid) begin
          we_d   = 1'b1;
          addr_d = pix_addr;
          data_d = bus.cam_data;
        end else if (bus.cpu_req && !bus.clr_start && !ack_q) begin
          // ack_q blocks the cycle where a held request still shows its
          // previous, already-serviced write.
          we_d   = 1'b1;
          ack_d  = 1'b1;
          addr_d = bus.cpu_addr;
          data_d = bus.cpu_data;
        end
        if (bus.clr_start) begin
          state_d   = CLEAR;
          color_d   = bus.clr_color;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (bus.cam_valid) ovr_d = 1'b1;
        we_d   = 1'b1;
        addr_d = clr_cnt;
        data_d = color;
        if (clr_cnt == LAST) begin
          cd_d      = 1'b1;
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.addr_in    = addr_q;
  assign bus.data_in    = data_q;
  assign bus.regwrite   = we_q;
  assign bus.cpu_ack    = ack_q;
  assign bus.busy       = (state == CLEAR);
  assign bus.frame_done = fd_q;
  assign bus.clr_done   = cd_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_buffer_wr_ctrl.sv
module tb_buffer_wr_ctrl;
  localparam int AW   = 15;
  localparam int DW   = 8;
  localparam int NPIX = 19200;
  localparam logic [AW-1:0] LAST_ADDR = 15'h4AFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_wr_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  buffer_wr_ctrl #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame-level bookkeeping with integer pointers.
  int            m_cam, m_cidx, m_pix;
  logic          m_clr, m_prev_ack;
  logic [DW-1:0] m_color;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_we, e_ack, e_fd, e_cd, e_ovr;

  logic [AW+DW+5:0] obs, expv;
  assign obs  = {bus.addr_in, bus.data_in, bus.regwrite, bus.cpu_ack, bus.busy,
                 bus.frame_done, bus.clr_done, bus.overrun};
  assign expv = {e_addr, e_data, e_we, e_ack, m_clr, e_fd, e_cd, e_ovr};

  task automatic model_step();
    if (rst) begin
      m_cam = 0; m_cidx = 0; m_clr = 1'b0; m_color = '0;
      e_addr = '0; e_data = '0; e_we = 0; e_ack = 0; e_fd = 0; e_cd = 0; e_ovr = 0;
    end else begin
      m_prev_ack = e_ack;
      e_we = 0; e_ack = 0; e_fd = 0; e_cd = 0;
      m_pix = bus.cam_sof ? 0 : m_cam;
      if (bus.cam_valid) begin
        e_fd  = (m_pix == NPIX - 1);
        m_cam = (m_pix + 1) % NPIX;
      end else if (bus.cam_sof) begin
        m_cam = 0;
      end
      if (!m_clr) begin
        if (bus.cam_sof) e_ovr = 0;
        if (bus.cam_valid) begin
          e_we = 1; e_addr = AW'(m_pix); e_data = bus.cam_data;
        end else if (bus.cpu_req && !bus.clr_start && !m_prev_ack) begin
          e_we = 1; e_ack = 1; e_addr = bus.cpu_addr; e_data = bus.cpu_data;
        end
        if (bus.clr_start) begin
          m_clr = 1'b1; m_cidx = 0; m_color = bus.clr_color;
        end
      end else begin
        if (bus.cam_valid) e_ovr = 1;
        e_we = 1; e_addr = AW'(m_cidx); e_data = m_color;
        if (m_cidx == NPIX - 1) begin
          e_cd = 1; m_clr = 1'b0;
        end else begin
          m_cidx++;
        end
      end
    end
  endtask

  // Advance one clock: model consumes the same inputs the DUT samples,
  // then outputs are observed 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cam_valid = 0; bus.cam_sof = 0; bus.cam_data = '0;
    bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.clr_start = 0; bus.clr_color = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    bus.cam_valid = 1; bus.cam_sof = 1; bus.cam_data = DW'($urandom);
    bus.cpu_req = 1; bus.cpu_addr = AW'($urandom); bus.cpu_data = DW'($urandom);
    bus.clr_start = 1; bus.clr_color = DW'($urandom);
    tick(); tick();
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    idle_inputs();
    tick();
    rst = 0;
    tick();
    checks++;
    if (bus.regwrite !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got we=%b busy=%b want 0 0", bus.regwrite, bus.busy);
    end
  endtask

  task automatic test_cam_seq();
    logic [DW-1:0] seq_d [3];
    seq_d[0] = 8'h11; seq_d[1] = 8'h22; seq_d[2] = 8'h33;
    for (int k = 0; k < 3; k++) begin
      bus.cam_sof = (k == 0); bus.cam_valid = 1; bus.cam_data = seq_d[k];
      tick();
      checks++;
      if (bus.regwrite !== 1'b1 || bus.addr_in !== AW'(k) || bus.data_in !== seq_d[k]) begin
        errors++;
        $display("FAIL cam_seq[%0d]: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                 k, bus.regwrite, bus.addr_in, bus.data_in, AW'(k), seq_d[k]);
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.regwrite !== 1'b0 || bus.addr_in !== 15'd2 || bus.data_in !== 8'h33) begin
      errors++;
      $display("FAIL cam_hold: got we=%b a=%h d=%h want we=0 a=0002 d=33",
               bus.regwrite, bus.addr_in, bus.data_in);
    end
  endtask

  task automatic test_frame();
    int fd_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      bus.cam_sof = (i == 0); bus.cam_valid = 1; bus.cam_data = DW'($urandom);
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL frame_model[%0d]: got %h want %h", i, obs, expv);
      end
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (i == NPIX - 1) begin
        checks++;
        if (bus.addr_in !== LAST_ADDR || bus.frame_done !== 1'b1 || bus.regwrite !== 1'b1) begin
          errors++;
          $display("FAIL frame_last: got a=%h fd=%b want a=%h fd=1", bus.addr_in, bus.frame_done, LAST_ADDR);
        end
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt);
    end
    bus.cam_sof = 0; bus.cam_valid = 1; bus.cam_data = DW'($urandom);
    tick();
    checks++;
    if (bus.addr_in !== '0 || bus.regwrite !== 1'b1 || bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL frame_wrap: got a=%h we=%b want a=0000 we=1", bus.addr_in, bus.regwrite);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_cpu_priority();
    int acks = 0, cpu_wr = 0, since = -1;
    bus.cpu_req = 1; bus.cpu_addr = 15'h0100; bus.cpu_data = 8'hAB;
    for (int k = 0; k < 3; k++) begin
      bus.cam_valid = 1; bus.cam_data = DW'($urandom);
      tick();
      checks++;
      if (obs !== expv || bus.cpu_ack !== 1'b0 || bus.regwrite !== 1'b1) begin
        errors++; $display("FAIL cpu_cam_first[%0d]: got %h want %h", k, obs, expv);
      end
    end
    bus.cam_valid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL cpu_model[%0d]: got %h want %h", k, obs, expv);
      end
      if (bus.cpu_ack === 1'b1) begin
        acks++; since = 0;
        if (bus.regwrite === 1'b1 && bus.addr_in === 15'h0100 && bus.data_in === 8'hAB) cpu_wr++;
      end else if (since >= 0) begin
        since++;
      end
      // CPU is slow to drop its request: still asserted one cycle past ack.
      if (since == 1) bus.cpu_req = 0;
    end
    checks++;
    if (acks != 1 || cpu_wr != 1) begin
      errors++; $display("FAIL cpu_single_ack: got acks=%0d writes=%0d want 1 1", acks, cpu_wr);
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt = 0, nxt = 0, cd_cnt = 0, acked = 0;
    logic [AW-1:0] cd_addr = '0;
    bus.cpu_req = 1; bus.cpu_addr = AW'($urandom); bus.cpu_data = DW'($urandom);
    bus.clr_start = 1; bus.clr_color = 8'hFF;
    for (int i = 0; i < NPIX + 20 && acked == 0; i++) begin
      tick();
      bus.clr_start = 0; bus.clr_color = DW'($urandom);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL clear_model[%0d]: got %h want %h", i, obs, expv);
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.cpu_ack === 1'b1) begin
        acked = 1;
        checks++;
        if (bus.busy !== 1'b0 || nxt != NPIX) begin
          errors++; $display("FAIL clear_ack_early: got busy=%b cleared=%0d want 0 %0d", bus.busy, nxt, NPIX);
        end
        bus.cpu_req = 0;
      end else if (bus.regwrite === 1'b1) begin
        if (bus.addr_in !== AW'(nxt) || bus.data_in !== 8'hFF) begin
          errors++; checks++;
          $display("FAIL clear_write: got a=%h d=%h want a=%h d=ff", bus.addr_in, bus.data_in, AW'(nxt));
        end
        nxt++;
      end
      if (bus.clr_done === 1'b1) begin cd_cnt++; cd_addr = bus.addr_in; end
    end
    checks++;
    if (acked == 0) begin
      errors++; $display("FAIL clear_ack_timeout: got no ack want ack after clear");
    end
    checks++;
    if (busy_cnt != NPIX || nxt != NPIX) begin
      errors++; $display("FAIL clear_span: got busy=%0d writes=%0d want %0d", busy_cnt, nxt, NPIX);
    end
    checks++;
    if (cd_cnt != 1 || cd_addr !== LAST_ADDR) begin
      errors++; $display("FAIL clr_done: got cnt=%0d a=%h want 1 %h", cd_cnt, cd_addr, LAST_ADDR);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_overrun();
    int done = 0;
    bus.clr_start = 1; bus.clr_color = DW'($urandom);
    tick();
    bus.clr_start = 0;
    for (int i = 0; i < 100; i++) tick();
    for (int k = 0; k < 4; k++) begin
      bus.cam_valid = (k != 2); bus.cam_sof = (k == 2); bus.cam_data = DW'($urandom);
      tick();
      checks++;
      if (obs !== expv || bus.overrun !== 1'b1) begin
        errors++; $display("FAIL overrun_set[%0d]: got %h want %h", k, obs, expv);
      end
    end
    idle_inputs();
    for (int i = 0; i < NPIX + 10 && done == 0; i++) begin
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL overrun_model[%0d]: got %h want %h", i, obs, expv);
      end
      if (bus.clr_done === 1'b1) done = 1;
    end
    checks++;
    if (done == 0) begin
      errors++; $display("FAIL overrun_clr_timeout: got no clr_done want clr_done");
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun);
    end
    bus.cam_sof = 1;
    tick();
    bus.cam_sof = 0;
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear: got %b want 0", bus.overrun);
    end
  endtask

  task automatic test_clear_abort();
    int found = 0, cd_seen = 0;
    bus.clr_start = 1; bus.clr_color = DW'($urandom);
    tick();
    bus.clr_start = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (bus.regwrite === 1'b1 && bus.addr_in === 15'h0200) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++; $display("FAIL abort_reach: got no write at 0200 want one");
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (bus.regwrite !== 1'b0 || bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      errors++; $display("FAIL abort_rst: got we=%b busy=%b cd=%b want 0 0 0",
                         bus.regwrite, bus.busy, bus.clr_done);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.clr_done === 1'b1 || bus.busy === 1'b1) cd_seen++;
    end
    checks++;
    if (cd_seen != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", cd_seen);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(499, 0) == 0);
      bus.cam_valid = $urandom_range(1, 0);
      bus.cam_sof = ($urandom_range(63, 0) == 0);
      bus.cam_data = DW'($urandom);
      if (!bus.cpu_req && $urandom_range(3, 0) == 0) begin
        bus.cpu_req = 1; bus.cpu_addr = AW'($urandom); bus.cpu_data = DW'($urandom);
      end
      tick();
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random_model[%0d]: got %h want %h", i, obs, expv);
      end
      if (bus.cpu_ack === 1'b1) bus.cpu_req = 0;
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_cam_seq();
    test_frame();
    test_cpu_priority();
    test_clear();
    test_overrun();
    test_clear_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
